// File: rtl/fir_pkg.sv
// Shared types and width helpers for the parameterised FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Worst-case growth: full product plus one bit per doubling of taps.
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Serial multiply-accumulate datapath with final arithmetic shift and saturation.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     cap,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, acc_nxt, shifted;
  logic signed [DATA_W-1:0] sat;

  assign prod    = PROD_W'(sample) * PROD_W'(coef);
  assign acc_nxt = acc + ACC_W'(prod);
  assign shifted = acc_nxt >>> SHIFT;

  always_comb begin
    sat = DATA_W'(shifted);
    if (shifted > SAT_MAX)      sat = DATA_W'(SAT_MAX);
    else if (shifted < SAT_MIN) sat = DATA_W'(SAT_MIN);
  end

  // The result is taken from acc_nxt so the last tap's product is included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (clr)     acc <= '0;
      else if (en) acc <= acc_nxt;
      if (cap) out_data <= sat;
    end
  end

endmodule

// File: rtl/fir_filter_param.sv
// Serial FIR filter: one MAC per cycle over a circular sample history, with
// run-time loadable coefficients and a valid/ready stream on both sides.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       busy
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW:0]   TAPS_L = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

  state_e state, state_nxt;

  logic [TAPS-1:0][DATA_W-1:0] hist;
  logic [TAPS-1:0][COEF_W-1:0] coef_mem;
  logic [AW-1:0]               wr_ptr, head, cnt, rd;
  logic [AW:0]                 rd_raw;
  logic                        fire, last, coef_wr;

  assign fire    = in_valid && in_ready;
  assign last    = (cnt == LAST);
  assign coef_wr = (state == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_L);

  // x[n-k] lives at (head - k) mod TAPS; TAPS need not be a power of two.
  always_comb begin
    rd_raw = {1'b0, head} + TAPS_L - {1'b0, cnt};
    if (rd_raw >= TAPS_L) rd_raw = rd_raw - TAPS_L;
    rd = rd_raw[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = MAC;
      MAC:     if (last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist   <= '0;
      wr_ptr <= '0;
      head   <= '0;
      cnt    <= '0;
    end else begin
      if (fire) begin
        hist[wr_ptr] <= in_data;
        head         <= wr_ptr;
        wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        cnt          <= '0;
      end else if (state == MAC) begin
        cnt <= last ? '0 : cnt + AW'(1);
      end
    end
  end

  // Reset leaves an identity filter: c[0] = 1.0 in the post-shift scale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coef_mem    <= '0;
      coef_mem[0] <= COEF_W'(1 << SHIFT);
    end else if (coef_wr) begin
      coef_mem[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (fire),
    .en      (state == MAC),
    .cap     ((state == MAC) && last),
    .sample  (hist[rd]),
    .coef    (coef_mem[cnt]),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param at default parameters (8/8/8 taps, shift 6).
module tb_fir_filter_param;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic              busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int mode;   // 0 identity, 1 c[k]=k+1, 2 c[0]=1 only, 3 all 127
    int din;
    int exp;
  } vec_t;

  vec_t vecs[$];

  fir_filter_param dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic load_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 8'(v);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic load_mode(input int m);
    for (int k = 0; k < 8; k++) begin
      int v;
      case (m)
        0:       v = (k == 0) ? 64 : 0;
        1:       v = k + 1;
        2:       v = (k == 0) ? 1 : 0;
        default: v = 127;
      endcase
      load_coef(k, v);
    end
  endtask

  task automatic start(input int d);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int y, output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_wait: got 0 expected 1");
    end
    y = out_data;
  endtask

  task automatic send(input int d, output int y, output int lat);
    start(d);
    wait_out(y, lat);
    @(negedge clk);
  endtask

  initial begin
    int y, lat, prev_mode, seen;

    // identity, then 8 zeros to flush history
    vecs.push_back(vec_t'{0, 5, 5});
    vecs.push_back(vec_t'{0, -7, -7});
    vecs.push_back(vec_t'{0, 127, 127});
    vecs.push_back(vec_t'{0, -128, -128});
    for (int i = 0; i < 8; i++) vecs.push_back(vec_t'{0, 0, 0});
    // impulse response of c[k]=k+1
    vecs.push_back(vec_t'{1, 64, 1});
    for (int i = 0; i < 7; i++) vecs.push_back(vec_t'{1, 0, i + 2});
    // floor behaviour of the arithmetic shift
    vecs.push_back(vec_t'{2, -1, -1});
    vecs.push_back(vec_t'{2, 63, 0});
    vecs.push_back(vec_t'{2, -65, -2});
    // saturation; the -128 run crosses zero at the fourth sample
    for (int i = 0; i < 8; i++) vecs.push_back(vec_t'{3, 127, 127});
    vecs.push_back(vec_t'{3, -128, 127});
    vecs.push_back(vec_t'{3, -128, 127});
    vecs.push_back(vec_t'{3, -128, 127});
    vecs.push_back(vec_t'{3, -128, -8});
    for (int i = 0; i < 4; i++) vecs.push_back(vec_t'{3, -128, -128});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);

    prev_mode = 0;
    foreach (vecs[i]) begin
      if (vecs[i].mode != prev_mode) load_mode(vecs[i].mode);
      prev_mode = vecs[i].mode;
      send(vecs[i].din, y, lat);
      check($sformatf("vec%0d_y", i), y, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 9);
    end

    // backpressure: hold OUT for 20 cycles with a sample waiting upstream
    load_mode(0);
    out_ready = 1'b0;
    start(33);
    wait_out(y, lat);
    check("bp_lat", lat, 9);
    in_valid = 1'b1;
    in_data  = 8'sd99;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_data%0d", i), out_data, 33);
      check($sformatf("bp_ready%0d", i), in_ready, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_idle", busy, 0);

    // coefficient writes during MAC must be dropped
    start(10);
    load_coef(0, 127);
    load_coef(1, 64);
    wait_out(y, lat);
    check("mac_we_cur", y, 10);
    @(negedge clk);
    send(20, y, lat);
    check("mac_we_next", y, 20);

    // reset during the k=3 MAC cycle
    start(50);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_data", out_data, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_output", seen, 0);

    // stale history would add 64*x to the sum; coef write lands before this MAC
    for (int k = 1; k < 8; k++) load_coef(k, 64);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'sd32;
    in_valid  = 1'b1;
    in_data   = 8'sd8;
    @(negedge clk);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_out(y, lat);
    check("post_abort_same_cycle_we", y, 4);
    check("post_abort_lat", lat, 9);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_filter_param.md
FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

Interface
REQ-001 Parameter DATA_W, default 8: signed sample width, input and output.
REQ-002 Parameter COEF_W, default 8: signed coefficient width.
REQ-003 Parameter TAPS, default 8: number of taps, range 2..64.
REQ-004 Parameter SHIFT, default 6: arithmetic right shift applied to the accumulator; legal range 0..COEF_W-2.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port in_data, input, DATA_W: signed input sample.
REQ-008 Port in_valid, input, 1: in_data valid.
REQ-009 Port in_ready, output, 1: block can accept a sample.
REQ-010 Port out_data, output, DATA_W: signed filtered sample.
REQ-011 Port out_valid, output, 1: out_data valid.
REQ-012 Port out_ready, input, 1: downstream accepts out_data.
REQ-013 Port coef_we, input, 1: coefficient write strobe.
REQ-014 Port coef_addr, input, clog2(TAPS): tap index k.
REQ-015 Port coef_data, input, COEF_W: signed coefficient value.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 The block SHALL compute y[n] = sat_DATA_W((sum over k=0..TAPS-1 of c[k]*x[n-k]) >>> SHIFT), two's complement throughout.
REQ-018 The accumulator SHALL be ACC_W = DATA_W+COEF_W+clog2(TAPS) bits and SHALL never overflow.
REQ-019 The shift SHALL be arithmetic (floor toward minus infinity); saturation SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 The sample history SHALL be a circular buffer of TAPS entries; the write pointer wraps from TAPS-1 to 0.
REQ-021 The FSM SHALL have states IDLE, MAC and OUT.
REQ-022 IDLE: in_ready=1; on in_valid&&in_ready, store in_data at the write pointer, advance the pointer, clear the accumulator, and go to MAC.
REQ-023 MAC: exactly one multiply-accumulate per cycle for TAPS cycles, k=0..TAPS-1, then go to OUT; in_ready=0.
REQ-024 OUT: out_valid=1 with out_data stable; on out_ready go to IDLE; hold indefinitely while out_ready=0.
REQ-025 Latency from the input handshake cycle to the first out_valid cycle SHALL be TAPS+1 cycles; throughput is one sample per TAPS+2 cycles with out_ready held high.
REQ-026 coef_we SHALL be honoured only in IDLE, writing c[coef_addr] at that edge; writes while busy=1 SHALL be ignored.
REQ-027 If coef_we and an input handshake occur in the same IDLE cycle, the coefficient write SHALL take effect before that sample's MAC.
REQ-028 coef_addr >= TAPS SHALL be ignored.

Reset
REQ-029 With rst_n=0 at a clock edge: state=IDLE, all history entries=0, write pointer=0, accumulator=0, out_valid=0, out_data=0, busy=0, in_ready=1 from the first cycle after reset release.
REQ-030 On reset, c[0] SHALL be set to 2^SHIFT and all other coefficients to 0, giving an identity filter.
REQ-031 Reset asserted during MAC or OUT SHALL abort the operation; no output for that sample is produced.

Structure
REQ-032 Package fir_pkg SHALL hold the FSM state enum and the ACC_W derivation function.
REQ-033 Sub-module fir_mac SHALL hold the multiplier, accumulator, and final shift/saturate datapath; the FSM, history buffer and coefficient storage SHALL stay in fir_filter_param.

Verification
REQ-034 After reset, with default parameters, inputs 5, -7, 127 SHALL produce outputs 5, -7, 127 in order.
REQ-035 Load c[k]=k+1, then send impulse 64 followed by seven zeros: outputs SHALL be 1,2,3,4,5,6,7,8.
REQ-036 Load all c[k]=127 and drive 127 for eight samples: outputs SHALL saturate to 127; with input -128 they SHALL saturate to -128.
REQ-037 Hold out_ready=0 for 20 cycles in OUT: out_valid and out_data SHALL stay stable and in_ready SHALL stay 0; the sample is delivered once out_ready=1.
REQ-038 A coef_we issued during MAC SHALL leave the current and the next outputs unchanged.
REQ-039 Reset pulsed during the MAC cycle for k=3 SHALL produce no output, and the next sample SHALL filter against an all-zero history.
